pipe_skid_reg: RTL
==================

# pipe_skid_reg

Elastic, parametrised pipeline register with a valid/ready handshake and a one-entry skid buffer. It replaces the fixed stall/flush-vector stage registers between EX→MEM, ID→EX and MEM→WB. It carries a PC, a control bundle and an opaque data payload. It sustains one transfer per cycle with a fully registered `in_ready`, so backpressure no longer needs a combinational stall path through the whole pipe.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC width.
- `CTRL_WIDTH`, 6, control bundle width.
- `DATA_WIDTH`, 128, payload width: ALU result, rs1/rs2 data, register indices, packed by the instantiating stage.
- `PC_ADDR`, 32'h8000_0000, reset value of `out_pc`.
- `CTRL_SAFE`, `pipe_pkg::CTRL_SAFE_DEFAULT` (MemSize=1, all others 0), control value used for bubbles and flushes.

Ports:
- `clk`, in, 1, clock; all state updates on the rising edge.
- `reset_n`, in, 1, synchronous active-low reset.
- `flush`, in, 1, synchronous kill of all held entries.
- `in_valid`, in, 1, upstream offers an entry.
- `in_ready`, out, 1, registered; stage can accept.
- `in_pc`, in, ADDR_WIDTH, PC of the offered entry.
- `in_ctrl`, in, CTRL_WIDTH, control bundle of the offered entry.
- `in_data`, in, DATA_WIDTH, payload of the offered entry.
- `out_valid`, out, 1, head entry valid.
- `out_ready`, in, 1, downstream accepts the head entry.
- `out_pc`, out, ADDR_WIDTH, PC of the head entry.
- `out_ctrl`, out, CTRL_WIDTH, control of the head entry; equals `CTRL_SAFE` whenever `out_valid`=0.
- `out_data`, out, DATA_WIDTH, payload of the head entry.
- `occupancy`, out, 2, number of held entries (0..2).

## Operation
- Storage: a main register (head, drives the outputs) and a skid register (holds an entry caught after `out_ready` drops).
- Handshake terms: input transfer `acc = in_valid & in_ready`; output transfer `pop = out_valid & out_ready`.
- FSM states `EMPTY`, `BUSY`, `FULL`. `occupancy` = 0, 1, 2 respectively.
- `EMPTY`:
  - `acc` → `BUSY`; main ← input.
- `BUSY`:
  - `acc & pop` → `BUSY`; main ← input.
  - `acc & !pop` → `FULL`; skid ← input.
  - `!acc & pop` → `EMPTY`.
  - Otherwise hold.
- `FULL`:
  - `pop` → `BUSY`; main ← skid.
  - `in_ready`=0, so no `acc` can occur.
- `in_ready` is registered and equals (next state != `FULL`).
- `out_valid` = (state != `EMPTY`).
- `out_ctrl` is muxed to `CTRL_SAFE` when `out_valid`=0. `out_pc` and `out_data` hold their last value.
- Flush (priority below reset, above everything else):
  - Next state is `EMPTY`; `in_ready` ← 1; any same-cycle `acc` or `pop` is discarded.
  - Main data ← 0; main ctrl ← `CTRL_SAFE`; `out_pc` ← `in_pc`, so the stage keeps the redirect PC.
- Reset (`reset_n`=0 at an edge): state `EMPTY`, `in_ready`=1, `out_valid`=0, `out_pc`=`PC_ADDR`, `out_ctrl`=`CTRL_SAFE`, `out_data`=0, `occupancy`=0. Skid contents are cleared to 0.
- Reset asserted mid-transfer drops both entries. Ordering is never violated; entries leave in acceptance order.

## Timing
- Latency: 1 cycle. Data accepted at edge N is on `out_*` with `out_valid`=1 after edge N.
- Throughput: 1 entry per cycle while `out_ready`=1.
- After `out_ready` falls, at most one further entry is accepted into skid. `in_ready` drops on the following edge.
- After `FULL`+`pop`, `in_ready` returns to 1 one edge later.
- No combinational path from `out_ready` to `in_ready`.
- Combinational paths are limited to the `out_ctrl` mask on `out_valid`.

## Structure
- `pipe_pkg` holds:
  - `typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_e`.
  - `typedef struct packed` `exmem_ctrl_t` with fields MemtoReg, RegWrite, MemWrite, MemRead, MemSize, Branch.
  - `CTRL_SAFE_DEFAULT`.
- Single module, no sub-module. Main and skid are two instances of the same register triplet inside one `always_ff`.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `in_valid`=1 → `out_valid`=0, `out_pc`=32'h8000_0000, `out_ctrl`=6'b000010 (MemSize only), `in_ready`=1, `occupancy`=0.
- Streaming: `out_ready`=1; offer PC 0x100, 0x104, 0x108 on consecutive cycles → the same PCs appear on `out_pc` one cycle later each, back-to-back, `occupancy`=1 throughout.
- Skid: with BUSY holding 0x100, drop `out_ready` while 0x104 is offered → `occupancy`=2, `in_ready`=0 next cycle. Raise `out_ready` → 0x100 then 0x104 pop in order, `in_ready`=1 one cycle after the first pop.
- Flush in `FULL` with `in_valid`=1, `in_pc`=0x200 → next cycle `out_valid`=0, `occupancy`=0, `out_pc`=0x200, `out_data`=0, `in_ready`=1. Neither held entry nor 0x200 is ever popped.
- Idle mask: after the last pop, `out_valid`=0 and `out_ctrl`=`CTRL_SAFE` while `out_data` retains its last value.
- Mid-operation reset: in `FULL`, assert `reset_n`=0 for 1 cycle → all reset values; a new entry offered the cycle after release is accepted and appears one cycle later.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage registers: FSM states and the
// EX->MEM control bundle with its bubble-safe value.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic MemtoReg;
    logic RegWrite;
    logic MemWrite;
    logic MemRead;
    logic MemSize;
    logic Branch;
  } exmem_ctrl_t;

  // Bubbles carry word-size accesses with every side-effecting bit cleared.
  localparam exmem_ctrl_t CTRL_SAFE_DEFAULT = '{
    MemtoReg: 1'b0,
    RegWrite: 1'b0,
    MemWrite: 1'b0,
    MemRead:  1'b0,
    MemSize:  1'b1,
    Branch:   1'b0
  };

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: main (head) entry plus a one-entry skid buffer,
// valid/ready handshake on both sides with a registered in_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    CTRL_WIDTH = 6,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(32'h8000_0000),
  parameter logic [CTRL_WIDTH-1:0] CTRL_SAFE  = CTRL_WIDTH'(CTRL_SAFE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  pipe_state_e state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  entry_t      in_entry;
  logic        in_ready_q;
  logic        acc, pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '{pc: PC_ADDR, ctrl: CTRL_SAFE, data: '0};
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  always_comb begin
    acc      = in_valid & in_ready_q;
    pop      = (state_q != EMPTY) & out_ready;
    in_entry = '{pc: in_pc, ctrl: in_ctrl, data: in_data};
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = BUSY;
          main_d  = in_entry;
        end
      end
      BUSY: begin
        if (acc && pop) begin
          main_d = in_entry;
        end else if (acc) begin
          state_d = FULL;
          skid_d  = in_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so the only way out is a pop.
        if (pop) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush keeps the redirect PC on the stage while killing both entries.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '{pc: in_pc, ctrl: CTRL_SAFE, data: '0};
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q != EMPTY);
    out_pc    = main_q.pc;
    out_data  = main_q.data;
    out_ctrl  = out_valid ? main_q.ctrl : CTRL_SAFE;
    unique case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
